// File: rtl/adjust_ctrl.sv
// adjust_ctrl: synchronises and debounces the mode/up/down buttons and steps the clock-adjust mode FSM.
// Auto-repeat of held up/down buttons is built only when ADJUST_CTRL_REPEAT_EN is defined.
module adjust_ctrl #(
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_field,
  output logic       up,
  output logic       Down,
  output logic       set_mode
);

  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_AHR  = 3'd3,
    ST_SET_AMIN = 3'd4
  } state_t;

  // Bit order in all button vectors: [0] mode, [1] up, [2] down.
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_db;
  logic [2:0]     r_db_q;
  logic [2:0]     r_press;
  logic [DBW-1:0] r_db_cnt [3];
  state_t         r_state;

  logic w_mode_ev;
  logic w_up_ev;
  logic w_dn_ev;
  logic w_up_only;
  logic w_dn_only;

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
  end

  function automatic state_t f_next_state(input state_t s);
    case (s)
      ST_RUN:      f_next_state = ST_SET_HR;
      ST_SET_HR:   f_next_state = ST_SET_MIN;
      ST_SET_MIN:  f_next_state = ST_SET_AHR;
      ST_SET_AHR:  f_next_state = ST_SET_AMIN;
      ST_SET_AMIN: f_next_state = ST_RUN;
      default:     f_next_state = ST_RUN;
    endcase
  endfunction

  function automatic logic [3:0] f_field(input state_t s);
    case (s)
      ST_RUN:      f_field = 4'b0000;
      ST_SET_HR:   f_field = 4'b0001;
      ST_SET_MIN:  f_field = 4'b0010;
      ST_SET_AHR:  f_field = 4'b0100;
      ST_SET_AMIN: f_field = 4'b1000;
      default:     f_field = 4'b0000;
    endcase
  endfunction

  assign w_mode_ev = r_press[0];
  assign w_up_ev   = r_press[1];
  assign w_dn_ev   = r_press[2];
  assign w_up_only = w_up_ev & ~w_dn_ev;
  assign w_dn_only = w_dn_ev & ~w_up_ev;

`ifdef ADJUST_CTRL_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = $clog2(REP_MAX + 1);

  logic           r_rep_act;
  logic           r_rep_dn;
  logic           r_rep_rate;
  logic [RPW-1:0] r_rep_cnt;
  logic           w_rep_hold;
  logic           w_rep_fire;
  logic [RPW-1:0] w_rep_limit;

  // Repeat continues only while the repeating button alone stays debounced-high.
  assign w_rep_hold  = r_rep_act & (r_rep_dn ? (r_db[2] & ~r_db[1]) : (r_db[1] & ~r_db[2]));
  assign w_rep_limit = r_rep_rate ? RPW'(REPEAT_RATE) : RPW'(REPEAT_DELAY);
  assign w_rep_fire  = w_rep_hold & (r_rep_cnt == w_rep_limit);
`endif

  // Input synchronisers, per-button debouncers and press-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_db    <= 3'b000;
      r_db_q  <= 3'b000;
      r_press <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= {DBW{1'b0}};
      end
    end else begin
      r_sync1 <= {btn_down, btn_up, btn_mode};
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= {DBW{1'b0}};
        end else if (r_db_cnt[i] == DBW'(DB_CYCLES)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= {DBW{1'b0}};
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Mode FSM with registered field enable and up/down pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      en_field <= 4'b0000;
      up       <= 1'b0;
      Down     <= 1'b0;
      set_mode <= 1'b0;
`ifdef ADJUST_CTRL_REPEAT_EN
      r_rep_act  <= 1'b0;
      r_rep_dn   <= 1'b0;
      r_rep_rate <= 1'b0;
      r_rep_cnt  <= {RPW{1'b0}};
`endif
    end else begin
      up   <= 1'b0;
      Down <= 1'b0;
      if (w_mode_ev) begin
        // Mode wins over any coincident up/down event.
        r_state  <= f_next_state(r_state);
        en_field <= f_field(f_next_state(r_state));
        set_mode <= (f_next_state(r_state) != ST_RUN);
`ifdef ADJUST_CTRL_REPEAT_EN
        r_rep_act <= 1'b0;
`endif
      end else if (r_state == ST_RUN) begin
`ifdef ADJUST_CTRL_REPEAT_EN
        r_rep_act <= 1'b0;
`endif
      end else if (w_up_only) begin
        up <= 1'b1;
`ifdef ADJUST_CTRL_REPEAT_EN
        r_rep_act  <= 1'b1;
        r_rep_dn   <= 1'b0;
        r_rep_rate <= 1'b0;
        r_rep_cnt  <= RPW'(1);
`endif
      end else if (w_dn_only) begin
        Down <= 1'b1;
`ifdef ADJUST_CTRL_REPEAT_EN
        r_rep_act  <= 1'b1;
        r_rep_dn   <= 1'b1;
        r_rep_rate <= 1'b0;
        r_rep_cnt  <= RPW'(1);
`endif
      end
`ifdef ADJUST_CTRL_REPEAT_EN
      else if (w_up_ev | w_dn_ev) begin
        r_rep_act <= 1'b0;
      end else if (w_rep_fire) begin
        up         <= ~r_rep_dn;
        Down       <= r_rep_dn;
        r_rep_rate <= 1'b1;
        r_rep_cnt  <= RPW'(1);
      end else if (w_rep_hold) begin
        r_rep_cnt <= r_rep_cnt + RPW'(1);
      end else begin
        r_rep_act <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adjust_ctrl.sv
// Self-checking bench for adjust_ctrl (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5).
// Expected output events are queued when buttons are driven and matched as the DUT emits them.
module tb_adjust_ctrl;

  localparam logic [1:0] EV_FIELD = 2'd0;
  localparam logic [1:0] EV_UP    = 2'd1;
  localparam logic [1:0] EV_DN    = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  field;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [3:0] en_field;
  logic       up;
  logic       Down;
  logic       set_mode;

  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  ev_t  q[$];
  logic       mon_en     = 1'b0;
  logic [3:0] prev_field = 4'b0000;
  logic [3:0] m_field    = 4'b0000;
  logic [3:0] st_field   = 4'b0000;

  adjust_ctrl #(
    .DB_CYCLES   (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn[0]),
    .btn_up  (btn[1]),
    .btn_down(btn[2]),
    .en_field(en_field),
    .up      (up),
    .Down    (Down),
    .set_mode(set_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] next_field(input logic [3:0] f);
    case (f)
      4'b0000: next_field = 4'b0001;
      4'b0001: next_field = 4'b0010;
      4'b0010: next_field = 4'b0100;
      4'b0100: next_field = 4'b1000;
      default: next_field = 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input logic [1:0] kind);
    ev_t obs;
    ev_t ex;
    obs = '{kind: kind, field: en_field, cyc: 32'(cyc)};
    n_assert++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL unexpected_event kind=%0d field=%b cyc=%0d required=none", kind, en_field, cyc);
    end
    if (q.size() > 0) begin
      ex = q.pop_front();
      n_assert++;
      assert (obs === ex) else begin
        n_fail++;
        $error("FAIL event observed kind=%0d field=%b cyc=%0d expected kind=%0d field=%b cyc=%0d",
               obs.kind, obs.field, obs.cyc, ex.kind, ex.field, ex.cyc);
      end
      if (ex.kind == EV_FIELD) m_field = ex.field;
    end
  endtask

  // Output monitor: every field change or pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (en_field !== prev_field) check_ev(EV_FIELD);
      prev_field = en_field;
      if (up === 1'b1) check_ev(EV_UP);
      if (Down === 1'b1) check_ev(EV_DN);
      n_assert++;
      assert (set_mode === (m_field != 4'b0000)) else begin
        n_fail++;
        $error("FAIL set_mode observed=%b expected=%b cyc=%0d", set_mode, (m_field != 4'b0000), cyc);
      end
      n_assert++;
      assert ((up & Down) === 1'b0) else begin
        n_fail++;
        $error("FAIL up_down_exclusive observed=%b expected=0 cyc=%0d", (up & Down), cyc);
      end
    end
  end

  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] field, input logic [31:0] at);
    q.push_back('{kind: kind, field: field, cyc: at});
  endtask

  task automatic hold_btns(input logic [2:0] mask, input int n);
    btn = btn | mask;
    repeat (n) @(negedge clk);
    btn = btn & ~mask;
  endtask

  task automatic mode_press();
    st_field = next_field(st_field);
    expect_ev(EV_FIELD, st_field, 32'(cyc + 9));
    hold_btns(3'b001, 10);
    repeat (10) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_assert++;
    assert (q.size() === 0) else begin
      n_fail++;
      $error("FAIL drain pending=%0d required=0 cyc=%0d", q.size(), cyc);
      q.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every button held.
    reset = 1'b1;
    btn   = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_en_field", 32'(en_field), 32'h0);
    check("rst_up", 32'(up), 32'h0);
    check("rst_down", 32'(Down), 32'h0);
    check("rst_set_mode", 32'(set_mode), 32'h0);
    reset      = 1'b0;
    prev_field = 4'b0000;
    m_field    = 4'b0000;
    st_field   = 4'b0001;
    expect_ev(EV_FIELD, 4'b0001, 32'(cyc + 9));
    mon_en = 1'b1;
    repeat (12) @(negedge clk);
    btn = 3'b000;
    drain();
    check("set_mode_after_first", 32'(set_mode), 32'h1);

    // Full mode wrap: 0010,0100,1000,0000,0001.
    for (int i = 0; i < 5; i++) mode_press();
    drain();

    // Bouncing up in SET_HR, then a solid hold: one up pulse.
    for (int i = 0; i < 3; i++) begin
      hold_btns(3'b010, 2);
      repeat (2) @(negedge clk);
    end
    expect_ev(EV_UP, st_field, 32'(cyc + 9));
    hold_btns(3'b010, 10);
    drain();

    // Down in SET_HR.
    expect_ev(EV_DN, st_field, 32'(cyc + 9));
    hold_btns(3'b100, 10);
    drain();

    // Back to RUN; up there is discarded.
    for (int i = 0; i < 4; i++) mode_press();
    drain();
    hold_btns(3'b010, 10);
    drain();

    // SET_MIN: simultaneous up+down discarded, then mode+up advances only.
    mode_press();
    mode_press();
    drain();
    hold_btns(3'b110, 10);
    drain();
    st_field = next_field(st_field);
    expect_ev(EV_FIELD, st_field, 32'(cyc + 9));
    hold_btns(3'b011, 10);
    drain();

    // Up in SET_AHR carries field 0100.
    expect_ev(EV_UP, st_field, 32'(cyc + 9));
    hold_btns(3'b010, 10);
    drain();

    // SET_AMIN: long down hold.
    mode_press();
    drain();
    expect_ev(EV_DN, st_field, 32'(cyc + 9));
`ifdef ADJUST_CTRL_REPEAT_EN
    for (int off = 20; off <= 50; off += 5) begin
      expect_ev(EV_DN, st_field, 32'(cyc + 9 + off));
    end
`endif
    hold_btns(3'b100, 54);
    drain();

    // Reset mid-debounce with mode still held: treated as a fresh press.
    btn = 3'b001;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_mid_en_field", 32'(en_field), 32'h0);
    check("rst_mid_set_mode", 32'(set_mode), 32'h0);
    prev_field = 4'b0000;
    m_field    = 4'b0000;
    st_field   = 4'b0001;
    expect_ev(EV_FIELD, 4'b0001, 32'(cyc + 9));
    mon_en = 1'b1;
    repeat (12) @(negedge clk);
    btn = 3'b000;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
